// File: rtl/exec_pkg.sv
// Shared execute-stage types: adder mode encoding, per-stage control register
// layout and the operand/chunk geometry check used at elaboration.
package exec_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        ADC = 2'd1,
        SUB = 2'd2,
        SBC = 2'd3
    } adder_op_t;

    // Control bits that move with each beat; wide data lives in separate arrays.
    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_a;
        logic msb_b;
    } stage_ctl_t;

    function automatic bit geometry_ok(input int bus, input int chunk);
        return (chunk > 0) && (bus >= chunk) && ((bus % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple-carry adder for one pipeline slice.
module chunk_adder #(
    parameter int width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < width; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one chunk of the carry chain resolved per stage,
// a single enable stalls the whole pipe, flags derived from the last stage.
module pipelined_adder
    import exec_pkg::*;
#(
    parameter int bus_size   = 32,
    parameter int chunk_size = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [bus_size-1:0] OPA,
    input  logic [bus_size-1:0] OPB,
    input  logic [1:0]          op,
    input  logic                carryIn,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bus_size-1:0] result,
    output logic                carryOut,
    output logic                zero,
    output logic                negative,
    output logic                overflow
);

    localparam int W      = bus_size;
    localparam int C      = chunk_size;
    localparam int STAGES = bus_size / chunk_size;

    if (!geometry_ok(bus_size, chunk_size)) begin : g_geometry_check
        $fatal(1, "pipelined_adder: bus_size must be a non-zero multiple of chunk_size");
    end

    // Valid/ready: a beat moves across an interface on a rising edge where
    // valid && ready; the whole pipe advances together when the output is
    // empty or being taken, so in_ready is combinational on out_ready.
    logic adv;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    adder_op_t op_e;
    logic [W-1:0] b_eff;
    logic         c0;

    assign op_e = adder_op_t'(op);

    always_comb begin
        b_eff = OPB;
        c0    = 1'b0;
        case (op_e)
            ADD: begin b_eff = OPB;  c0 = 1'b0;    end
            ADC: begin b_eff = OPB;  c0 = carryIn; end
            SUB: begin b_eff = ~OPB; c0 = 1'b1;    end
            SBC: begin b_eff = ~OPB; c0 = carryIn; end
            default: begin b_eff = OPB; c0 = 1'b0; end
        endcase
    end

    stage_ctl_t   ctl_q [STAGES];
    stage_ctl_t   ctl_d [STAGES];
    logic [W-1:0] a_q   [STAGES];
    logic [W-1:0] a_d   [STAGES];
    logic [W-1:0] b_q   [STAGES];
    logic [W-1:0] b_d   [STAGES];
    logic [W-1:0] res_q [STAGES];
    logic [W-1:0] res_d [STAGES];

    // Operands shift down one chunk per stage so each stage always consumes
    // the low chunk; finished sum chunks enter at the top and shift down.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0]   a_in;
        logic [W-1:0]   b_in;
        logic [W-1:0]   r_in;
        logic           c_in;
        logic           v_in;
        logic           ma_in;
        logic           mb_in;
        logic [C-1:0]   sum;
        logic           cout;
        logic [W+C-1:0] r_cat;

        if (k == 0) begin : g_first
            assign a_in  = OPA;
            assign b_in  = b_eff;
            assign r_in  = '0;
            assign c_in  = c0;
            assign v_in  = in_valid;
            assign ma_in = OPA[W-1];
            assign mb_in = b_eff[W-1];
        end else begin : g_next
            assign a_in  = a_q[k-1];
            assign b_in  = b_q[k-1];
            assign r_in  = res_q[k-1];
            assign c_in  = ctl_q[k-1].carry;
            assign v_in  = ctl_q[k-1].valid;
            assign ma_in = ctl_q[k-1].msb_a;
            assign mb_in = ctl_q[k-1].msb_b;
        end

        chunk_adder #(.width(C)) u_chunk (
            .a    (a_in[C-1:0]),
            .b    (b_in[C-1:0]),
            .cin  (c_in),
            .sum  (sum),
            .cout (cout)
        );

        assign r_cat    = {sum, r_in};
        assign res_d[k] = r_cat[W+C-1:C];
        assign a_d[k]   = a_in >> C;
        assign b_d[k]   = b_in >> C;
        assign ctl_d[k] = '{valid: v_in, carry: cout, msb_a: ma_in, msb_b: mb_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                ctl_q[i] <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                ctl_q[i] <= ctl_d[i];
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign result    = res_q[STAGES-1];
    assign carryOut  = ctl_q[STAGES-1].carry;
    assign negative  = result[W-1];
    // Gated so an empty or reset pipe never reports a zero result.
    assign zero      = out_valid && (result == '0);
    assign overflow  = (ctl_q[STAGES-1].msb_a == ctl_q[STAGES-1].msb_b)
                    && (result[W-1] != ctl_q[STAGES-1].msb_a);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at bus_size=8, chunk_size=4 (two stages).
module tb_pipelined_adder;
    import exec_pkg::*;

    localparam int W = 8;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] OPA       = '0;
    logic [W-1:0] OPB       = '0;
    logic [1:0]   op        = 2'd0;
    logic         carryIn   = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         carryOut;
    logic         zero;
    logic         negative;
    logic         overflow;

    pipelined_adder #(.bus_size(W), .chunk_size(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OPA       (OPA),
        .OPB       (OPB),
        .op        (op),
        .carryIn   (carryIn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryOut  (carryOut),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o, input logic c, input logic v);
        OPA      = a;
        OPB      = b;
        op       = o;
        carryIn  = c;
        in_valid = v;
    endtask

    task automatic check_flags(input string tag, input logic [W-1:0] r, input logic c,
                               input logic z, input logic n, input logic v);
        check({tag, "_valid"},    out_valid, 1);
        check({tag, "_result"},   result, r);
        check({tag, "_carry"},    carryOut, c);
        check({tag, "_zero"},     zero, z);
        check({tag, "_negative"}, negative, n);
        check({tag, "_overflow"}, overflow, v);
    endtask

    task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] o, input logic c,
                             input logic [W-1:0] er, input logic ec, input logic ez,
                             input logic en, input logic ev);
        @(negedge clk);
        drive(a, b, o, c, 1'b1);
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check_flags(tag, er, ec, ez, en, ev);
    endtask

    logic [W-1:0] bp_a   [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    logic [W-1:0] bp_b   [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [W-1:0] bp_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int sent;
        int rcvd;
        int stall_left;
        int first_dlv;
        int last_dlv;
        bit seen;

        // reset state
        #1 rst_n = 1'b0;
        #1;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_result",    result, 0);
        check("rst_carry",     carryOut, 0);
        check("rst_zero",      zero, 0);
        check("rst_negative",  negative, 0);
        check("rst_overflow",  overflow, 0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed single beats
        single_op("add_7f_01",  8'h7F, 8'h01, 2'(ADD), 1'b0, 8'h80, 0, 0, 1, 1);
        single_op("sub_05_05",  8'h05, 8'h05, 2'(SUB), 1'b0, 8'h00, 1, 1, 0, 0);
        single_op("adc_ff_00",  8'hFF, 8'h00, 2'(ADC), 1'b1, 8'h00, 1, 1, 0, 0);
        single_op("sbc_00_01",  8'h00, 8'h01, 2'(SBC), 1'b0, 8'hFE, 0, 0, 1, 0);
        single_op("add_0f_01",  8'h0F, 8'h01, 2'(ADD), 1'b0, 8'h10, 0, 0, 0, 0);
        single_op("sub_80_01",  8'h80, 8'h01, 2'(SUB), 1'b0, 8'h7F, 1, 0, 0, 1);
        single_op("add_cin_ig", 8'h01, 8'h01, 2'(ADD), 1'b1, 8'h02, 0, 0, 0, 0);
        single_op("sub_cin_ig", 8'h10, 8'h01, 2'(SUB), 1'b0, 8'h0F, 1, 0, 0, 0);
        single_op("adc_c0",     8'h34, 8'h12, 2'(ADC), 1'b0, 8'h46, 0, 0, 0, 0);

        // backpressure: four back-to-back beats, 3-cycle stall at first output
        sent = 0; rcvd = 0; stall_left = 0; first_dlv = -1; last_dlv = -1; seen = 0;
        for (int cyc = 0; cyc < 30 && rcvd < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen       = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (sent < 4) drive(bp_a[sent], bp_b[sent], 2'(ADD), 1'b0, 1'b1);
            else in_valid = 1'b0;
            #1;
            if (!out_ready) check("bp_stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_exp[sent]);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL bp_extra_beat: observed 0x%0h expected no beat", result);
                end else begin
                    check("bp_result", result, exp_q.pop_front());
                    rcvd++;
                    if (first_dlv < 0) first_dlv = cyc;
                    last_dlv = cyc;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_received",   rcvd, 4);
        check("bp_first_dlv",  first_dlv, 5);
        check("bp_last_dlv",   last_dlv, 8);
        check("bp_queue_left", exp_q.size(), 0);

        // reset mid-flight with two beats in the pipe
        @(negedge clk);
        drive(8'hF0, 8'h90, 2'(ADD), 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h11, 8'h22, 2'(ADD), 1'b0, 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_flags("pre_rst", 8'h80, 1, 0, 1, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready",  in_ready, 1);
        check("mid_rst_result",    result, 0);
        check("mid_rst_carry",     carryOut, 0);
        check("mid_rst_zero",      zero, 0);
        check("mid_rst_negative",  negative, 0);
        check("mid_rst_overflow",  overflow, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        single_op("post_rst", 8'h0F, 8'h01, 2'(ADD), 1'b0, 8'h10, 0, 0, 0, 0);

        // final report
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. The carry chain is split into `chunk_size`-bit slices, with one slice evaluated and registered per stage, so wide operands close timing at the execute-stage clock. It supports four modes (ADD, ADC, SUB, SBC) and reports zero, negative, carry and signed-overflow flags aligned with the result. It sits in the execute stage as the arithmetic datapath feeding the ALU result mux.

## Interface
- `bus_size`, default 32: operand and result width; must be a multiple of `chunk_size`.
- `chunk_size`, default 8: bits resolved per pipeline stage; STAGES = bus_size/chunk_size.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand beat present.
- `in_ready` output 1: block accepts the beat this cycle.
- `OPA`, `OPB` input bus_size: operands.
- `op` input 2: mode, one of ADD=0, ADC=1, SUB=2, SBC=3.
- `carryIn` input 1: carry used by ADC and SBC; ignored by ADD and SUB.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: consumer takes the beat.
- `result` output bus_size: sum or difference.
- `carryOut`, `zero`, `negative`, `overflow` output 1 each: flags for `result`.

## Operation
- Effective operand B' = OPB for ADD and ADC, ~OPB for SUB and SBC.
- Effective carry-in c0 is 0 for ADD, carryIn for ADC, 1 for SUB, carryIn for SBC.
- result = (OPA + B' + c0) mod 2^bus_size.
- carryOut is the bit bus_size carry. For SUB/SBC, carryOut=1 means no borrow.
- zero is 1 when result is all zeros.
- negative = result[bus_size-1].
- overflow = (OPA[msb] == B'[msb]) && (result[msb] != OPA[msb]).
- Stage k (0..STAGES-1) adds chunk k of OPA and B' with the carry registered by stage k-1 (c0 for stage 0).
- Each stage registers its sum chunk, its carry, and a valid bit.
- The upper unprocessed operand chunks travel forward in the pipeline registers.
- Completed lower result chunks travel forward in skew registers.
- Operand MSBs travel forward for the overflow computation.
- Flags are computed combinationally from the final stage's registers.
- Pipeline enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, all stages shift one step; a stage with no valid input loads valid=0.
  - When adv=0, every register holds.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Accept and deliver may occur in the same cycle; throughput is one beat per cycle with no bubble.
- Results emerge in acceptance order; no beat is dropped or duplicated.
- Reset (rst_n low, any time including mid-flight):
  - all valid bits clear immediately; out_valid=0 and in_ready=1 during reset;
  - result, carryOut, zero, negative and overflow read 0;
  - in-flight beats are discarded and never emerge.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES register stages), provided no stall.
- chunk_size == bus_size: single stage, latency 1 register.
- A stall adds one cycle per cycle with out_ready=0 while out_valid=1.
- in_ready depends combinationally on out_ready (no skid buffer).
- The upstream stage must hold its inputs stable while in_valid=1 and in_ready=0.
- Combinational depth per stage is one chunk_size-bit ripple plus register setup.

## Structure
- Shared package `exec_pkg`:
  - `adder_op_t` enum (ADD, ADC, SUB, SBC);
  - stage-register struct typedef;
  - elaboration check that bus_size % chunk_size == 0 (fatal otherwise).
- Sub-module `chunk_adder`: a combinational chunk_size-bit ripple adder with ports a, b, cin, sum, cout, instantiated once per stage inside a generate loop.
- Top level holds the pipeline registers, the handshake enable and the flag logic.

## Test plan
All directed cases use bus_size=8, chunk_size=4 (STAGES=2) with out_ready held 1 unless stated.
- ADD 0x7F+0x01 -> result 0x80, carryOut 0, overflow 1, negative 1, zero 0; out_valid exactly 2 edges after accept.
- SUB 0x05-0x05 -> result 0x00, zero 1, carryOut 1, overflow 0, negative 0.
- ADC 0xFF+0x00 with carryIn=1 -> result 0x00, carryOut 1, zero 1.
- SBC 0x00-0x01 with carryIn=0 -> result 0xFE, carryOut 0, negative 1, overflow 0.
- Backpressure:
  - stimulus: 4 back-to-back beats (0x10+0x01, 0x20+0x02, 0x30+0x03, 0x40+0x04), with out_ready=0 for 3 cycles after the first out_valid;
  - response: results 0x11, 0x22, 0x33, 0x44 in order, none lost; in_ready=0 throughout the stall; full rate afterwards.
- Reset mid-flight:
  - stimulus: assert rst_n=0 asynchronously between edges while 2 beats are in the pipe;
  - response: out_valid falls at once and all outputs read 0; after release, out_valid stays 0 until a new beat is accepted.
